// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults, sync polarity and the stage-0 control bundle
// shared by the scanout blocks.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;

    localparam logic HSYNC_ACT = 1'b0;
    localparam logic VSYNC_ACT = 1'b0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{hs: ~HSYNC_ACT, vs: ~VSYNC_ACT, de: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters and the combinational stage-0 sync, enable and
// frame-start controls derived from them.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output vga_ctrl_t        ctrl0
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        ctrl0    = CTRL_IDLE;
        ctrl0.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        ctrl0.hs = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HSYNC_ACT : ~HSYNC_ACT;
        ctrl0.vs = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VSYNC_ACT : ~VSYNC_ACT;
        ctrl0.fs = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Framebuffer scanout: walks the 32x32 tile grid in step with VGA timing and
// aligns the RAM's registered read data with the delayed sync/enable controls.
module vga_fb_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int CELL_W     = 20,
    parameter int CELL_H     = 15,
    parameter int addr_width = 10,
    parameter int data_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [addr_width-1:0] mem_addr,
    input  logic [data_width-1:0] mem_dout,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [data_width-1:0] pixel,
    output logic                  frame_start
);

    localparam int AXIS_W = addr_width / 2;
    localparam int CX_W   = $clog2(CELL_W + 1);
    localparam int CY_W   = $clog2(CELL_H + 1);

    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CX_W-1:0]  CX_LAST    = CX_W'(CELL_W - 1);
    localparam logic [CY_W-1:0]  CY_LAST    = CY_W'(CELL_H - 1);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    vga_ctrl_t         ctrl0;
    vga_ctrl_t         ctrl_d1;
    logic [CX_W-1:0]   cell_x;
    logic [CY_W-1:0]   cell_y;
    logic [AXIS_W-1:0] col;
    logic [AXIS_W-1:0] row;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .ctrl0 (ctrl0)
    );

    // col clears on the last visible pixel so blanking already presents column 0;
    // row overflowing past the last tile row wraps to 0 for vertical blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_x <= '0;
            col    <= '0;
            cell_y <= '0;
            row    <= '0;
        end else begin
            if (h_cnt == H_ACT_LAST) begin
                cell_x <= '0;
                col    <= '0;
            end else if (h_cnt < H_ACT) begin
                if (cell_x == CX_LAST) begin
                    cell_x <= '0;
                    col    <= col + 1'b1;
                end else begin
                    cell_x <= cell_x + 1'b1;
                end
            end

            if (h_cnt == H_LAST) begin
                if (v_cnt == V_LAST) begin
                    cell_y <= '0;
                    row    <= '0;
                end else if (v_cnt < V_ACT) begin
                    if (cell_y == CY_LAST) begin
                        cell_y <= '0;
                        row    <= row + 1'b1;
                    end else begin
                        cell_y <= cell_y + 1'b1;
                    end
                end
            end
        end
    end

    assign mem_addr = {row, col};

    // Stage d1 lines up with the RAM read in flight; the output stage captures both.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_d1     <= CTRL_IDLE;
            hsync       <= ~HSYNC_ACT;
            vsync       <= ~VSYNC_ACT;
            de          <= 1'b0;
            pixel       <= '0;
            frame_start <= 1'b0;
        end else begin
            ctrl_d1     <= ctrl0;
            hsync       <= ctrl_d1.hs;
            vsync       <= ctrl_d1.vs;
            de          <= ctrl_d1.de;
            pixel       <= ctrl_d1.de ? mem_dout : '0;
            frame_start <= ctrl_d1.fs;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench: a full-size scanout and a shrunken-timing scanout run side by
// side against a cycle-count based reference model of the raster.
module tb_vga_fb_reader;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int cw; int ch;
    } cfg_t;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [3:0] pixel;
        logic       fs;
        logic [9:0] addr;
    } obs_t;

    localparam cfg_t C_F = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, cw: 20, ch: 15};
    localparam cfg_t C_S = '{ha: 64, hf: 4, hs: 8, hb: 4, va: 64, vf: 2, vs: 2, vb: 3, cw: 2, ch: 2};
    localparam int HT_S  = 80;
    localparam int VT_S  = 71;
    localparam int FT_S  = HT_S * VT_S;
    localparam int N_CYC = 29000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_f, rst_s;
    logic [9:0] addr_f, addr_s;
    logic [3:0] dout_f, dout_s, pix_f, pix_s;
    logic       hs_f, vs_f, de_f, fs_f;
    logic       hs_s, vs_s, de_s, fs_s;

    logic [3:0] mem_f [1024];
    logic [3:0] mem_s [1024];

    vga_fb_reader u_full (
        .clk (clk), .rst (rst_f), .mem_addr (addr_f), .mem_dout (dout_f),
        .hsync (hs_f), .vsync (vs_f), .de (de_f), .pixel (pix_f), .frame_start (fs_f)
    );

    vga_fb_reader #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (64), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .CELL_W (2), .CELL_H (2), .addr_width (10), .data_width (4)
    ) u_small (
        .clk (clk), .rst (rst_s), .mem_addr (addr_s), .mem_dout (dout_s),
        .hsync (hs_s), .vsync (vs_s), .de (de_s), .pixel (pix_s), .frame_start (fs_s)
    );

    always @(posedge clk) begin
        dout_f <= mem_f[addr_f];
        dout_s <= mem_s[addr_s];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
            if (n_chk - n_pass >= 40) begin
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        end
    endtask

    function automatic logic [9:0] exp_addr(cfg_t c, int t);
        int ht, vt, h, v, col, row;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        h   = t % ht;
        v   = (t / ht) % vt;
        col = (h < c.ha) ? h / c.cw : 0;
        row = (v < c.va) ? v / c.ch : 0;
        return 10'(row * 32 + col);
    endfunction

    // Output after the next edge: t is the count in the current cycle, tp the
    // previous cycle's count whose raster position is now reaching the pins.
    function automatic obs_t make_exp(cfg_t c, int t, int tp, logic rp, logic rn, logic [3:0] word);
        obs_t o;
        int ht, vt, h, v;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        h  = tp % ht;
        v  = (tp / ht) % vt;
        o.addr = rn ? 10'd0 : exp_addr(c, t + 1);
        if (rn || rp) begin
            o.hsync = 1'b1; o.vsync = 1'b1; o.de = 1'b0; o.pixel = 4'd0; o.fs = 1'b0;
        end else begin
            o.de    = (h < c.ha) && (v < c.va);
            o.hsync = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
            o.vsync = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
            o.pixel = o.de ? word : 4'd0;
            o.fs    = (h == 0) && (v == 0);
        end
        return o;
    endfunction

    obs_t q_f[$];
    obs_t q_s[$];

    int   t_f, tp_f, t_s, tp_s;
    logic rp_f, rp_s;
    logic dir_done = 1'b0;

    initial begin
        for (int k = 0; k < 1024; k++) begin
            mem_f[k] = 4'(k);
            mem_s[k] = 4'($urandom);
        end
        rst_f = 1'b1; rst_s = 1'b1;
        t_f = 0; tp_f = 0; rp_f = 1'b1;
        t_s = 0; tp_s = 0; rp_s = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < N_CYC; n++) begin
            logic rn;
            int   h, v;
            rn = 1'b0;
            h  = t_s % HT_S;
            v  = (t_s / HT_S) % VT_S;
            if (n > 3 * FT_S + 10 && t_s > 300) begin
                if (!dir_done && h == 30 && v == 20) begin
                    rn = 1'b1;
                    dir_done = 1'b1;
                end else if (dir_done && $urandom_range(0, 1999) == 0) begin
                    rn = 1'b1;
                end
            end
            q_s.push_back(make_exp(C_S, t_s, tp_s, rp_s, rn, mem_s[exp_addr(C_S, tp_s)]));
            q_f.push_back(make_exp(C_F, t_f, tp_f, rp_f, 1'b0, mem_f[exp_addr(C_F, tp_f)]));
            rst_s = rn;
            rst_f = 1'b0;
            tp_s = t_s; t_s = rn ? 0 : t_s + 1; rp_s = rn;
            tp_f = t_f; t_f = t_f + 1;          rp_f = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        chk("mid_line_reset_issued", int'(dir_done), 1);
        finish_run();
    end

    int   since_f = 0, since_s = 0;
    logic armed_f = 1'b0, armed_s = 1'b0;
    int   fs_cnt = 0, hs_low = 0, vs_low = 0;
    logic pa_done = 1'b0;
    obs_t e;

    task automatic finish_run();
        if (armed_f && since_f > C_F.ha + C_F.hf + 2) chk("f_first_hsync_fall_timeout", since_f, C_F.ha + C_F.hf + 2);
        if (armed_s && since_s > C_S.ha + C_S.hf + 2) chk("s_first_hsync_fall_timeout", since_s, C_S.ha + C_S.hf + 2);
        if (!pa_done) chk("s_frame_window_reached", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_f) begin since_f = 0; armed_f = 1'b1; end else since_f++;
        if (rst_s) begin since_s = 0; armed_s = 1'b1; end else since_s++;

        if (armed_f && !rst_f && hs_f == 1'b0) begin
            chk("f_first_hsync_fall", since_f, C_F.ha + C_F.hf + 2);
            armed_f = 1'b0;
        end
        if (armed_s && !rst_s && hs_s == 1'b0) begin
            chk("s_first_hsync_fall", since_s, C_S.ha + C_S.hf + 2);
            armed_s = 1'b0;
        end

        if (!pa_done && !rst_s && since_s >= 2 && since_s < 2 + 3 * FT_S) begin
            fs_cnt += int'(fs_s);
            hs_low += int'(!hs_s);
            vs_low += int'(!vs_s);
        end
        if (!pa_done && since_s == 2 + 3 * FT_S) begin
            chk("s_frame_starts_in_3_frames", fs_cnt, 3);
            chk("s_hsync_low_in_3_frames", hs_low, 3 * VT_S * C_S.hs);
            chk("s_vsync_low_in_3_frames", vs_low, 3 * C_S.vs * HT_S);
            pa_done = 1'b1;
        end

        if (q_f.size() > 0) begin
            e = q_f.pop_front();
            chk("f_mem_addr", int'(addr_f), int'(e.addr));
            chk("f_hsync", int'(hs_f), int'(e.hsync));
            chk("f_vsync", int'(vs_f), int'(e.vsync));
            chk("f_de", int'(de_f), int'(e.de));
            chk("f_pixel", int'(pix_f), int'(e.pixel));
            chk("f_frame_start", int'(fs_f), int'(e.fs));
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("s_mem_addr", int'(addr_s), int'(e.addr));
            chk("s_hsync", int'(hs_s), int'(e.hsync));
            chk("s_vsync", int'(vs_s), int'(e.vsync));
            chk("s_de", int'(de_s), int'(e.de));
            chk("s_pixel", int'(pix_s), int'(e.pixel));
            chk("s_frame_start", int'(fs_s), int'(e.fs));
        end
    end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Scanout engine that reads the 1024×4 tile framebuffer RAM and drives the VGA output. It generates 640×480@60 timing, presents one framebuffer read address per pixel clock, absorbs the RAM's one-cycle registered read latency, and emits pixel data aligned with hsync, vsync and display-enable. It is the read-side counterpart of the framebuffer writer: the writer fills tiles, and this block displays them as a 32×32 grid of 20×15-pixel cells.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (frame total 525)
- CELL_W / CELL_H, 20 / 15, pixels per cell horizontally and vertically
- addr_width, 10, framebuffer address width ({row[4:0], col[4:0]})
- data_width, 4, framebuffer word and pixel width

Ports:
- clk  in  1  pixel clock, 25 MHz nominal
- rst  in  1  synchronous, active-high reset
- mem_addr  out  addr_width  framebuffer read address
- mem_dout  in  data_width  RAM read data, valid one clk after the address is sampled
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  display enable, high for visible pixels
- pixel  out  data_width  pixel colour; 0 whenever de=0
- frame_start  out  1  one-clk pulse coincident with output pixel (0,0)

## Operation
- Counters h_cnt (0..799) and v_cnt (0..524) advance every clk.
  - h wraps 799→0.
  - v increments on h wrap and wraps 524→0 on its own wrap.
- Cell tracking avoids division:
  - cell_x (0..CELL_W-1) and col (0..31) advance only while h_cnt < H_ACTIVE.
  - When cell_x reaches CELL_W-1, it returns to 0 and col increments.
  - At h_cnt = H_ACTIVE-1, both cell_x and col clear to 0. They hold through horizontal blanking, which prefetches column 0.
  - At h_cnt = 799 with v_cnt < V_ACTIVE, cell_y increments. When cell_y = CELL_H-1, it returns to 0 and row increments.
  - At v wrap (h=799, v=524), cell_y and row clear.
- mem_addr = {row, col} is driven from registered state and is valid every clk, including blanking.
- Stage-0 controls are derived from counters:
  - de0 = h<640 && v<480.
  - hs0 low for 656 ≤ h < 752.
  - vs0 low for 490 ≤ v < 492.
  - fs0 = (h==0 && v==0).
- The stage-0 controls are delayed two registered stages. pixel is registered as de_d1 ? mem_dout : 0.
- Reset values:
  - hsync=1, vsync=1, de=0, pixel=0, frame_start=0.
  - mem_addr=0.
  - All counters and pipeline registers are 0 or inactive.
- Reset mid-frame takes effect on the next edge: all outputs return to reset values and timing restarts from h=0, v=0. No partial pipeline contents escape.

## Timing
- Output latency is 2 clk from counter state to hsync/vsync/de/pixel. All outputs are registered.
  - Edge k: counters = c; the RAM samples mem_addr.
  - Edge k+1: the output registers capture mem_dout and the delayed controls for c.
- The first de=1 after rst deasserts appears 2 clk after the first counted cycle.
- mem_addr changes at most once per clk. Within a line it changes every CELL_W clk.
- Simultaneous h wrap and v wrap: row, cell_y and col all clear on the same edge. fs0 is asserted for the following cycle.

## Structure
- Shared package vga_timing_pkg holds the VGA timing constants (active, porch and sync values, totals) and sync polarity.
- Natural sub-module: vga_timing_gen (h/v counters, stage-0 hs/vs/de/fs). vga_fb_reader adds the cell/address logic and the latency pipeline.

## Test plan
1. **Reset then free-run:** release rst, count 420000 clk. Required: exactly one frame_start pulse per 420000 clk; hsync low 96 of every 800 clk; vsync low for 1600 clk per frame.
2. **Address sequence on line 0:**
   - mem_addr=0 for h=0..19, 1 for h=20..39, 31 for h=620..639.
   - mem_addr holds 0 for h=640..799.
3. **Row stepping:**
   - mem_addr is 0..31 on lines v=0..14 and 32..63 on line v=15.
   - Line v=479 covers 992..1023.
   - mem_addr=0 through vertical blanking.
4. **Data alignment:** RAM model with 1-clk registered read and mem[k]=k[3:0]. Required:
   - Output pixel x=25, y=0 is 1; x=339, y=16 is 0 (addr 48).
   - The first pixel after frame_start is 0.
   - pixel=0 whenever de=0.
5. **Reset mid-line:** assert rst for 1 clk at h=300, v=200. On the next edge:
   - de=0, hsync=1, vsync=1, pixel=0, mem_addr=0.
   - First hsync falling edge occurs 658 clk after rst deasserts.
